ram_fifo_ctrl: RTL and testbench

RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

---
 rtl/ram_fifo_pkg.sv | 11 +
 rtl/ram_fifo_ctrl.sv | 73 +++++++
 tb/tb_ram_fifo_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/ram_fifo_pkg.sv
// ram_fifo_pkg: shared sizing constants for the RAM-backed FIFO controller
//   DW    - data word width (matches the external RAM word)
//   AW    - RAM address width
//   DEPTH - number of FIFO entries (2**AW)
//   CW    - occupancy counter width (holds 0..DEPTH)
package ram_fifo_pkg;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 2 ** AW;
    localparam int CW    = AW + 1;
endpackage

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: FIFO controller driving a single-port RAM (one access per cycle)
//   clk, rst            - clock, asynchronous active-high reset
//   wr_valid/ready/data - push handshake; wr_ready drops when full or a pop owns the RAM
//   rd_req              - pop request; rd_valid pulses one cycle later with rd_data
//   full, empty, count  - registered occupancy state
//   ovf, udf, clr_err   - sticky overflow/underflow flags and their clear
//   ram_*               - single-port RAM bus; ram_dout is combinational on reads
module ram_fifo_ctrl #(
    parameter int DW = ram_fifo_pkg::DW,
    parameter int AW = ram_fifo_pkg::AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_req,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          ovf,
    output logic          udf,
    input  logic          clr_err,
    output logic          ram_ena,
    output logic          ram_wena,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count_n;
    logic          pop, push;

    // Pop owns the single RAM port, so a concurrent push is held off
    assign pop      = rd_req && !empty;
    assign wr_ready = !rst && !full && !pop;
    assign push     = wr_valid && wr_ready;

    always_comb begin
        ram_ena  = pop || push;
        ram_wena = push;
        ram_addr = pop ? rd_ptr : push ? wr_ptr : '0;
        ram_din  = push ? wr_data : '0;
        count_n  = push ? count + 1'b1 : pop ? count - 1'b1 : count;
    end

    // Flags are registered from the next count so they never glitch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            ovf      <= 1'b0;
            udf      <= 1'b0;
        end else begin
            rd_ptr   <= rd_ptr + AW'(pop);
            wr_ptr   <= wr_ptr + AW'(push);
            count    <= count_n;
            empty    <= count_n == '0;
            full     <= count_n[AW];
            rd_valid <= pop;
            rd_data  <= pop ? ram_dout : rd_data;
            ovf      <= (wr_valid && full) || (ovf && !clr_err);
            udf      <= (rd_req && empty) || (udf && !clr_err);
        end
    end
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl: directed table-driven bench for ram_fifo_ctrl with a behavioral single-port RAM
module tb_ram_fifo_ctrl;
    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 0;
    logic          rst = 0;
    logic          wr_valid = 0, rd_req = 0, clr_err = 0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ready, rd_valid, full, empty, ovf, udf;
    logic [DW-1:0] rd_data, ram_din;
    wire  [DW-1:0] ram_dout;
    logic [AW:0]   count;
    logic          ram_ena, ram_wena;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] mem [32];

    int total = 0;
    int bad = 0;
    logic [31:0] lrd;

    always #5 clk = ~clk;

    always @(posedge clk) if (ram_ena && ram_wena) mem[ram_addr] <= ram_din;
    assign ram_dout = (ram_ena && !ram_wena) ? mem[ram_addr] : 'z;

    ram_fifo_ctrl #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_req(rd_req), .rd_valid(rd_valid), .rd_data(rd_data),
        .full(full), .empty(empty), .count(count),
        .ovf(ovf), .udf(udf), .clr_err(clr_err),
        .ram_ena(ram_ena), .ram_wena(ram_wena), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    typedef struct {
        logic        wv;
        logic [31:0] wd;
        logic        rr;
        logic        ce;
        logic        ewr;
        logic        erv;
        logic [31:0] erd;
        int          ecnt;
        logic        eovf;
        logic        eudf;
    } vec_t;

    function automatic vec_t mk(input logic wv, input logic [31:0] wd, input logic rr, input logic ce,
                                input logic ewr, input logic erv, input logic [31:0] erd, input int ecnt,
                                input logic eovf, input logic eudf);
        vec_t v;
        v.wv = wv; v.wd = wd; v.rr = rr; v.ce = ce;
        v.ewr = ewr; v.erv = erv; v.erd = erd; v.ecnt = ecnt; v.eovf = eovf; v.eudf = eudf;
        return v;
    endfunction

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", n, a, e, $time);
        end
    endtask

    // Entered at posedge+1; leaves at the next posedge+1 with inputs idled
    task automatic step(input vec_t v, input string nm);
        wr_valid = v.wv; wr_data = v.wd; rd_req = v.rr; clr_err = v.ce;
        @(negedge clk);
        chk({nm, ".wr_ready"}, 32'(wr_ready), 32'(v.ewr));
        @(posedge clk);
        #1;
        chk({nm, ".rd_valid"}, 32'(rd_valid), 32'(v.erv));
        chk({nm, ".rd_data"}, rd_data, v.erd);
        chk({nm, ".count"}, 32'(count), 32'(v.ecnt));
        chk({nm, ".empty"}, 32'(empty), 32'(v.ecnt == 0));
        chk({nm, ".full"}, 32'(full), 32'(v.ecnt == 32));
        chk({nm, ".ovf"}, 32'(ovf), 32'(v.eovf));
        chk({nm, ".udf"}, 32'(udf), 32'(v.eudf));
        wr_valid = 0; rd_req = 0; clr_err = 0; wr_data = '0;
    endtask

    task automatic rst_pulse(input string nm);
        rst = 1;
        #1;
        chk({nm, ".count"}, 32'(count), 0);
        chk({nm, ".empty"}, 32'(empty), 1);
        chk({nm, ".full"}, 32'(full), 0);
        chk({nm, ".rd_valid"}, 32'(rd_valid), 0);
        chk({nm, ".rd_data"}, rd_data, 0);
        chk({nm, ".ovf_udf"}, {30'd0, ovf, udf}, 0);
        chk({nm, ".ram_ena"}, {30'd0, ram_ena, ram_wena}, 0);
        @(posedge clk);
        #1;
        rst = 0;
        lrd = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[$];
        #3;
        rst_pulse("reset0");

        // basic order, underflow/clear interplay, simultaneous push+pop
        tbl.push_back(mk(1, 32'h11111111, 0, 0, 1, 0, 32'h0, 1, 0, 0));
        tbl.push_back(mk(1, 32'h22222222, 0, 0, 1, 0, 32'h0, 2, 0, 0));
        tbl.push_back(mk(1, 32'h33333333, 0, 0, 1, 0, 32'h0, 3, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 1, 32'h11111111, 2, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 1, 32'h22222222, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 1, 32'h33333333, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 32'h33333333, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 32'h33333333, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 32'h33333333, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 0, 32'h33333333, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 32'h33333333, 0, 0, 0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(1, 32'hA0 + 32'(i), 0, 0, 1, 0, 32'h33333333, i + 1, 0, 0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1, 32'hFF, 1, 0, 0, 1, 32'hA0 + 32'(i), 4 - i, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 1, 32'hA3, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 1, 32'hA4, 0, 0, 0));
        foreach (tbl[i]) step(tbl[i], $sformatf("tbl%0d", i));

        // fill to full, overflow, then wrap both pointers
        rst_pulse("reset1");
        for (int i = 0; i < 32; i++) step(mk(1, 32'(i), 0, 0, 1, 0, lrd, i + 1, 0, 0), $sformatf("fill%0d", i));
        step(mk(1, 32'hDEAD, 0, 0, 0, 0, lrd, 32, 1, 0), "ovf");
        step(mk(0, 0, 0, 1, 0, 0, lrd, 32, 0, 0), "ovf_clr");
        for (int i = 0; i < 20; i++) begin
            lrd = 32'(i);
            step(mk(0, 0, 1, 0, 0, 1, lrd, 31 - i, 0, 0), $sformatf("pop%0d", i));
        end
        for (int i = 0; i < 20; i++) step(mk(1, 100 + 32'(i), 0, 0, 1, 0, lrd, 13 + i, 0, 0), $sformatf("wrap%0d", i));
        for (int j = 0; j < 32; j++) begin
            lrd = j < 12 ? 32'(20 + j) : 32'(100 + j - 12);
            step(mk(0, 0, 1, 0, 0, 1, lrd, 31 - j, 0, 0), $sformatf("drain%0d", j));
        end

        // reset mid-stream discards queued words
        rst_pulse("reset2");
        for (int i = 0; i < 10; i++) step(mk(1, 200 + 32'(i), 0, 0, 1, 0, 0, i + 1, 0, 0), $sformatf("pre%0d", i));
        step(mk(0, 0, 1, 0, 0, 1, 200, 9, 0, 0), "pre_pop");
        rst_pulse("reset3");
        step(mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 1), "post_udf");
        step(mk(1, 32'h5A, 0, 1, 1, 0, 0, 1, 0, 0), "post_push");
        step(mk(0, 0, 1, 0, 0, 1, 32'h5A, 0, 0, 0), "post_pop");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
